flow_dequantizer: RTL and testbench
===================================

FLOW_DEQUANTIZER -- requirements
Module: flow_dequantizer

Interface
REQ-001 Parameter: N, default 2, coefficients per beat; legal values are 1, 2, 4 and 8 (each divides 64).
REQ-002 Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  global pipeline enable.
- tbl_wr  in  1  quant table write strobe.
- tbl_addr  in  6  table index (zigzag order, 0..63).
- tbl_data  in  10  unsigned quant value.
- in_valid  in  1  input beat valid.
- in_data  in  N x 16  signed quantized coefficients.
- in_sob  in  1  first beat of an 8x8 block.
- in_eob  in  1  last beat of an 8x8 block.
- in_sof  in  1  first beat of a frame.
- out_valid  out  1  output beat valid.
- out_data  out  N x 16  signed dequantized coefficients.
- out_sob, out_eob, out_sof  out  1 each  delayed flags.
- out_err  out  1  block framing error pulse, aligned with out_eob.

Function
REQ-003 The block SHALL compute out_data[k] = sat16(in_data[k] * Q[idx+k]), where Q is a 64 x 10-bit table.
REQ-004 The product SHALL be signed 16 x unsigned 10 -> signed 27 bits. Saturation: above 32767 -> 32767; below -32768 -> -32768.
REQ-005 A Q value of 0 SHALL be legal and SHALL yield 0.
REQ-006 Latency SHALL be exactly 3 enabled cycles: table read, multiply, saturate/register.
- valid and all flags SHALL travel in lock-step with data.
- When en=0, every pipeline stage and the index counter SHALL hold.
REQ-007 Index counter idx (6 bits) SHALL advance only on en & in_valid.
- Base for a beat: 0 if in_sob=1, else idx.
- After the beat: idx <= base + N, modulo 64.
REQ-008 A beat with in_eob=1 whose base != 64-N SHALL produce out_err=1 on the output beat carrying that eob; otherwise out_err SHALL be 0.
REQ-009 A beat with in_sob=1 arriving mid-block SHALL restart at base 0 with no error flagged.
REQ-010 Beats with in_valid=0 SHALL NOT advance idx and SHALL emit out_valid=0.
- Data and flags on such beats are don't-care.
- out_err SHALL be 0 on such beats.
REQ-011 tbl_wr SHALL write Q[tbl_addr] <= tbl_data on the same edge, independent of en.
REQ-012 A read of the same address in the cycle of a write SHALL return the old value; the new value is visible from the next cycle.
REQ-013 Table writes during streaming SHALL be permitted without stalling the stream.
REQ-014 in_sof SHALL only be delayed; it SHALL NOT affect idx (in_sob governs).

Reset
REQ-015 On rst=1 at a clock edge, regardless of en:
- out_valid, out_sob, out_eob, out_sof, out_err, and all internal valid/flag stages SHALL clear to 0.
- out_data SHALL clear to 0.
- idx SHALL clear to 0.
- every Q entry SHALL reset to 1 (identity).
REQ-016 Reset asserted mid-block SHALL discard in-flight beats; the next block SHALL start at idx 0.
REQ-017 When rst and tbl_wr are both asserted, reset SHALL take priority.

Structure
REQ-018 The shared JPEG package SHALL hold:
- the coefficient width (16);
- the quant width (10);
- the block size constant (64);
- the saturation limits.
REQ-019 One sub-module flow_dequant_lane (multiply + saturate, 2 register stages) SHALL be instantiated N times by generate.
REQ-020 The table SHALL be an N-read-port register array inside flow_dequantizer.

Verification
REQ-021 After reset with no writes: N=2, block of 32 beats with in_data = {3, -5} -> out_data = {3, -5}, 3 cycles later; out_err=0.
REQ-022 Load Q[i] = i+1, then stream all-ones data -> beat j outputs {2j+1, 2j+2}; out_sob on the first beat, out_eob on the 32nd.
REQ-023 Saturation: Q[0] = 1023.
- in_data[0] = 100 -> 32767.
- in_data[0] = -100 -> -32768.
- in_data[0] = 32 -> 32736.
REQ-024 Stall: toggle en 0/1 every cycle mid-block -> outputs identical to the unstalled run; latency 3 enabled cycles.
REQ-025 Framing: in_eob on beat 20 of a block -> out_err=1 with that out_eob. Next in_sob beat -> uses Q[0], Q[1].
REQ-026 Write Q[5] = 7 in the same cycle a beat reads index 4..5 -> old Q[5] is used; the next block uses 7. Assert rst mid-block -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/flow_dequantizer_pkg.sv
// Shared JPEG dequantizer constants, beat flag bundle and the 16-bit saturation helper.
package flow_dequantizer_pkg;

  localparam int unsigned COEF_W   = 16;
  localparam int unsigned QUANT_W  = 10;
  localparam int unsigned BLK_SIZE = 64;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned PROD_W   = COEF_W + QUANT_W + 1;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(SAT_MAX);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(SAT_MIN);

  typedef struct packed {
    logic valid;
    logic sob;
    logic eob;
    logic sof;
    logic err;
  } beat_flags_t;

  function automatic logic signed [COEF_W-1:0] sat16(input logic signed [PROD_W-1:0] p);
    if (p > SAT_HI) return COEF_W'(SAT_MAX);
    if (p < SAT_LO) return COEF_W'(SAT_MIN);
    return p[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/flow_dequant_lane.sv
// One coefficient lane: signed x unsigned multiply, then saturate to 16 bits (two register stages).
module flow_dequant_lane
  import flow_dequantizer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [COEF_W-1:0] coef,
  input  logic [QUANT_W-1:0]       q,
  output logic signed [COEF_W-1:0] dq
);

  logic signed [PROD_W-1:0] prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      dq   <= '0;
    end else if (en) begin
      // zero-extend q so the product stays signed
      prod <= PROD_W'(coef) * PROD_W'($signed({1'b0, q}));
      dq   <= sat16(prod);
    end
  end

endmodule

// File: rtl/flow_dequantizer.sv
// Streaming JPEG dequantizer: per-beat zigzag index, 64-entry quant table, N parallel lanes.
module flow_dequantizer
  import flow_dequantizer_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  tbl_wr,
  input  logic [IDX_W-1:0]      tbl_addr,
  input  logic [QUANT_W-1:0]    tbl_data,
  input  logic                  in_valid,
  input  logic [N*COEF_W-1:0]   in_data,
  input  logic                  in_sob,
  input  logic                  in_eob,
  input  logic                  in_sof,
  output logic                  out_valid,
  output logic [N*COEF_W-1:0]   out_data,
  output logic                  out_sob,
  output logic                  out_eob,
  output logic                  out_sof,
  output logic                  out_err
);

  logic [QUANT_W-1:0]       qtab [BLK_SIZE];
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         base;
  logic signed [COEF_W-1:0] s1_coef [N];
  logic [QUANT_W-1:0]       s1_q    [N];
  logic signed [COEF_W-1:0] lane_dq [N];
  beat_flags_t              s1_f, s2_f, s3_f;

  always_comb begin
    base = in_sob ? '0 : idx;
  end

  // Table writes ignore en; reads in the same cycle see the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BLK_SIZE; i++) qtab[i] <= QUANT_W'(1);
    end else if (tbl_wr) begin
      qtab[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      s1_f <= '0;
      s2_f <= '0;
      s3_f <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        s1_coef[k] <= '0;
        s1_q[k]    <= '0;
      end
    end else if (en) begin
      if (in_valid) idx <= base + IDX_W'(N);
      s1_f <= '{valid: in_valid,
                sob:   in_valid & in_sob,
                eob:   in_valid & in_eob,
                sof:   in_valid & in_sof,
                err:   in_valid & in_eob & (base != IDX_W'(BLK_SIZE - N))};
      for (int unsigned k = 0; k < N; k++) begin
        s1_coef[k] <= in_data[k*COEF_W +: COEF_W];
        s1_q[k]    <= qtab[base + IDX_W'(k)];
      end
      s2_f <= s1_f;
      s3_f <= s2_f;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    flow_dequant_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .coef (s1_coef[g]),
      .q    (s1_q[g]),
      .dq   (lane_dq[g])
    );
    assign out_data[g*COEF_W +: COEF_W] = lane_dq[g];
  end

  assign out_valid = s3_f.valid;
  assign out_sob   = s3_f.sob;
  assign out_eob   = s3_f.eob;
  assign out_sof   = s3_f.sof;
  assign out_err   = s3_f.err;

endmodule

// File: tb/tb_flow_dequantizer.sv
// Scoreboard bench for flow_dequantizer: reference model predicts each output beat and its arrival edge.
module tb_flow_dequantizer;

  localparam int N = 2;
  localparam int W = N * 16;

  logic          clk = 1'b0;
  logic          rst, en, tbl_wr, in_valid, in_sob, in_eob, in_sof;
  logic [5:0]    tbl_addr;
  logic [9:0]    tbl_data;
  logic [W-1:0]  in_data;
  logic          out_valid, out_sob, out_eob, out_sof, out_err;
  logic [W-1:0]  out_data;

  flow_dequantizer #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .tbl_wr(tbl_wr), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .in_valid(in_valid), .in_data(in_data), .in_sob(in_sob),
    .in_eob(in_eob), .in_sof(in_sof), .out_valid(out_valid), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   f;      // sob, eob, sof, err
    int unsigned  due;    // enabled-edge number the beat must appear on
  } exp_t;

  exp_t        sb[$];
  int          qm[64];
  int          midx;
  int unsigned ecnt;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dq(input int c, input int q);
    longint p = longint'(c) * longint'(q);
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  // Predicts the effect of the upcoming rising edge from the inputs now driven.
  task automatic model_update();
    exp_t e;
    int   b;
    if (rst) begin
      foreach (qm[i]) qm[i] = 1;
      midx = 0;
      sb.delete();
      return;
    end
    if (en && in_valid) begin
      b = in_sob ? 0 : midx;
      for (int k = 0; k < N; k++) begin
        logic signed [15:0] c;
        c = in_data[k*16 +: 16];
        e.d[k*16 +: 16] = dq(int'(c), qm[(b + k) % 64]);
      end
      e.f   = {in_sob, in_eob, in_sof, in_eob && (b != 64 - N)};
      e.due = ecnt + 3;
      sb.push_back(e);
      midx = (b + N) % 64;
    end
    if (tbl_wr) qm[tbl_addr] = int'(tbl_data);
  endtask

  task automatic cyc();
    model_update();
    @(negedge clk);
  endtask

  task automatic beat(input logic [W-1:0] d, input logic sob, input logic eob, input logic sof);
    in_valid = 1'b1; in_data = d; in_sob = sob; in_eob = eob; in_sof = sof;
    cyc();
    in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
  endtask

  task automatic wr(input int a, input int v);
    tbl_wr = 1'b1; tbl_addr = 6'(a); tbl_data = 10'(v);
    cyc();
    tbl_wr = 1'b0;
  endtask

  task automatic block(input logic [W-1:0] d, input int beats, input bit rnd);
    for (int j = 0; j < beats; j++)
      beat(rnd ? W'({$urandom, $urandom}) : d, j == 0, j == beats - 1, j == 0);
  endtask

  // Monitor: samples just after each edge, pops only on enabled edges with out_valid.
  initial begin
    logic rs, es;
    exp_t e;
    ecnt = 0;
    forever begin
      @(posedge clk);
      rs = rst; es = en;
      if (!rs && es) ecnt++;
      #1;
      if (rs) begin
        chk("reset_outputs", 64'({out_valid, out_sob, out_eob, out_sof, out_err, out_data}), 64'd0);
      end else if (es) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(out_data), 64'hDEAD);
          end else begin
            e = sb.pop_front();
            chk("data", 64'(out_data), 64'(e.d));
            chk("flags", 64'({out_sob, out_eob, out_sof, out_err}), 64'(e.f));
            chk("latency", 64'(ecnt), 64'(e.due));
          end
        end else begin
          chk("idle_err", 64'(out_err), 64'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; tbl_wr = 1'b0; tbl_addr = '0; tbl_data = '0;
    in_valid = 1'b0; in_data = '0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    repeat (3) cyc();
    rst = 1'b0; en = 1'b1;
    cyc();

    // identity table
    block({16'hFFFB, 16'd3}, 32, 1'b0);
    repeat (4) cyc();

    // Q[i] = i+1 with all-ones data
    for (int i = 0; i < 64; i++) wr(i, i + 1);
    block({16'd1, 16'd1}, 32, 1'b0);
    repeat (4) cyc();

    // saturation through Q[0] = 1023
    wr(0, 1023);
    beat({16'd5, 16'd100}, 1'b1, 1'b0, 1'b0);
    beat({16'd5, 16'hFF9C}, 1'b1, 1'b0, 1'b0);
    beat({16'd5, 16'd32}, 1'b1, 1'b0, 1'b0);
    beat({16'h8000, 16'h7FFF}, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc();

    // en toggling every cycle mid-block
    for (int j = 0; j < 32; j++) begin
      logic [W-1:0] d;
      d = W'({$urandom, $urandom});
      en = 1'b0; beat(d, j == 0, j == 31, 1'b0);
      en = 1'b1; beat(d, j == 0, j == 31, 1'b0);
    end
    repeat (4) cyc();

    // early eob on beat 20, then a fresh block
    block('0, 20, 1'b1);
    block('0, 32, 1'b1);
    // sob mid-block restarts cleanly
    block('0, 7, 1'b1);
    block('0, 32, 1'b1);
    repeat (4) cyc();

    // write Q[5] while beat 2 reads 4..5, then reuse
    beat(W'({$urandom, $urandom}), 1'b1, 1'b0, 1'b1);
    beat(W'({$urandom, $urandom}), 1'b0, 1'b0, 1'b0);
    tbl_wr = 1'b1; tbl_addr = 6'd5; tbl_data = 10'd7;
    beat({16'd2, 16'd3}, 1'b0, 1'b0, 1'b0);
    tbl_wr = 1'b0;
    for (int j = 3; j < 32; j++) beat(W'({$urandom, $urandom}), 1'b0, j == 31, 1'b0);
    block({16'd2, 16'd3}, 32, 1'b0);

    // reset mid-block; next beat starts at index 0 with identity table
    block('0, 5, 1'b1);
    rst = 1'b1; tbl_wr = 1'b1; tbl_addr = 6'd0; tbl_data = 10'd9;
    beat(W'({$urandom, $urandom}), 1'b0, 1'b0, 1'b0);
    rst = 1'b0; tbl_wr = 1'b0;
    for (int j = 0; j < 32; j++) beat(W'({$urandom, $urandom}), 1'b0, j == 31, 1'b0);
    repeat (4) cyc();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sob   = ($urandom_range(0, 15) == 0);
      in_eob   = ($urandom_range(0, 15) == 0);
      in_sof   = ($urandom_range(0, 63) == 0);
      in_data  = ($urandom_range(0, 7) == 0) ? {16'h8000, 16'h7FFF} : W'({$urandom, $urandom});
      tbl_wr   = ($urandom_range(0, 7) == 0);
      tbl_addr = 6'($urandom);
      tbl_data = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      cyc();
    end

    rst = 1'b0; en = 1'b1; in_valid = 1'b0; tbl_wr = 1'b0;
    in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    repeat (6) cyc();
    chk("drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
